uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single SoC UART transmit line between two byte producers: the CPU console path (port 0) and the DFU bootloader response path (port 1).
- Contains the arbiter, the RTS/CTS flow gate and an 8N1 serializer.
- Sits between the peripheral bus UART register block and the top-level uart_tx / uart_cts pins of wrapper.
- DFU mode gives the bootloader strict priority. Otherwise ports are served round-robin, one byte per grant.

Parameters:
CLKS_PER_BIT, 145, clock cycles per UART bit (16.67 MHz / 115200); legal range 2..65535
CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
dfu  input  1  1 = DFU mode, port 1 has strict priority
req0_valid  input  1  CPU byte available
req0_data  input  8  CPU byte
req0_ready  output  1  CPU byte accepted this cycle when req0_valid=1
req1_valid  input  1  DFU byte available
req1_data  input  8  DFU byte
req1_ready  output  1  DFU byte accepted this cycle when req1_valid=1
uart_cts  input  1  active-low clear-to-send from peer; 0 = peer may receive
uart_tx  output  1  serial line, idle high
busy  output  1  frame in progress (state != IDLE)
grant  output  2  one-hot owner of current or last frame (bit0 = CPU, bit1 = DFU)

Behaviour:
- States: IDLE, START, DATA, [PARITY], STOP. All state is registered on posedge clk.
- Reset values: uart_tx=1, busy=0, grant=2'b00, req0_ready=0, req1_ready=0, state=IDLE, baud counter=0, bit index=0, last-grant pointer=port 1 (so port 0 wins the first round-robin tie).
- reqN_ready is combinational and high only when all of these hold:
  - state=IDLE
  - uart_cts=0
  - port N is the selected requester
- At most one ready is high per cycle. The transfer occurs when valid && ready on the same cycle.
- Selection in IDLE:
  - dfu=1: port 1 if req1_valid, else port 0.
  - dfu=0: if both ports are valid, pick the port not equal to the last-grant pointer; if only one is valid, pick it.
- On accept:
  - Data is latched into the shift register.
  - grant is set one-hot to the accepted port and the last-grant pointer is updated.
  - Next state is START. The requester may change its data from the following cycle.
- START: uart_tx=0 for CLKS_PER_BIT cycles, beginning the cycle after accept (latency 1).
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back throughput is one frame per 10*CLKS_PER_BIT+1 cycles, because IDLE costs one cycle.
- uart_cts is sampled only in IDLE. A deassert mid-frame never aborts or stretches the frame; the next frame waits until uart_cts=0.
- Changing dfu mid-frame affects only the next arbitration.
- grant holds its value after the frame completes, until the next accept.
- Reset asserted mid-frame: on the next edge, uart_tx=1, state=IDLE and all reset values apply. The partial frame is dropped, not resent.
- busy=1 from the cycle after accept through the last STOP cycle.

Optional Feature:
- Macro: UART_TX_ARB_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT cycles (8E1).
- When undefined: no PARITY state, no parity logic, 8N1 framing.

Test Plan (bench uses CLKS_PER_BIT=4):
- Single byte: uart_cts=0, req0_valid=1, req0_data=8'hA5 -> req0_ready=1 for one cycle; uart_tx sequence per 4 cycles = 0,1,0,1,0,0,1,0,1,1; busy=1 for 40 cycles; grant=2'b01.
- Round-robin: dfu=0, both ports valid continuously (8'h11, 8'h22) -> accepts alternate port0, port1, port0, port1; accepts are 41 cycles apart.
- DFU priority: dfu=1, both valid -> four consecutive frames all from port 1 (8'h22); req0_ready stays 0 throughout.
- Flow control: uart_cts=1, req0_valid=1 -> no ready, uart_tx=1 for 100 cycles. uart_cts=0 -> accept on the same cycle. uart_cts=1 raised mid-frame -> frame completes in full 40 cycles, next accept is blocked.
- Reset mid-frame: reset=1 at cycle 15 of a frame -> next cycle uart_tx=1, busy=0, grant=2'b00. After release, both valid -> port 0 accepted first.
- With UART_TX_ARB_PARITY_EN, 8'h07 -> parity bit=1 after data, frame 44 cycles. With 8'h03 -> parity bit=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-port UART transmit arbiter with RTS/CTS gating and 8N1 serializer.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 145,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dfu,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       uart_cts,
  output logic       uart_tx,
  output logic       busy,
  output logic [1:0] grant
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_ARB_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       data_q;
  logic             tx_q;
  logic             busy_q;
  logic [1:0]       grant_q;
  logic             last_q;  // 1 = port 1 owned the last frame

  logic sel1, can_accept, accept0, accept1, bit_end;

  always_comb begin
    sel1       = req1_valid & (dfu | ~req0_valid | ~last_q);
    can_accept = ~reset & (state_q == StIdle) & ~uart_cts;
    req1_ready = can_accept & sel1;
    req0_ready = can_accept & ~sel1 & req0_valid;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
    bit_end    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept0 || accept1) begin
            data_q    <= accept1 ? req1_data : req0_data;
            grant_q   <= accept1 ? 2'b10 : 2'b01;
            last_q    <= accept1;
            state_q   <= StStart;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StData;
            tx_q    <= data_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
              state_q <= StParity;
              tx_q    <= ^data_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= data_q[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_ARB_PARITY_EN
        StParity: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StStop;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with CLKS_PER_BIT=4.
module tb_uart_tx_arbiter;

  localparam int Cpb = 4;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FrameLen = 11 * Cpb;
`else
  localparam int FrameLen = 10 * Cpb;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dfu = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       uart_cts = 1'b0;
  logic       uart_tx;
  logic       busy;
  logic [1:0] grant;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_tx_arbiter #(.CLKS_PER_BIT(Cpb), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .dfu        (dfu),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .uart_cts   (uart_cts),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .grant      (grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge with inputs settled; returns at the accepting negedge.
  task automatic wait_accept(output int port);
    port = -1;
    for (int n = 0; n < 300; n++) begin
      if (req0_valid && req0_ready) begin port = 0; break; end
      if (req1_valid && req1_ready) begin port = 1; break; end
      @(negedge clk);
      #1;
    end
    if (port < 0) check("accept_timeout", 0, 1);
  endtask

  // Checks every frame cycle, then the following idle cycle.
  task automatic check_frame(input logic [7:0] d, input logic [1:0] g, input int cts_drop);
    logic [10:0] fr;
`ifdef UART_TX_ARB_PARITY_EN
    fr = {1'b1, ^d, d, 1'b0};
`else
    fr = {2'b01, d, 1'b0};
`endif
    for (int k = 0; k < FrameLen; k++) begin
      @(negedge clk);
      check("frame_tx", uart_tx, fr[k / Cpb]);
      check("frame_busy", busy, 1);
      check("frame_no_ready", {req1_ready, req0_ready}, 2'b00);
      if (k == 0) check("frame_grant", grant, g);
      if (k == cts_drop) uart_cts = 1'b1;
    end
    @(negedge clk);
    #1;
    check("post_busy", busy, 0);
    check("post_tx", uart_tx, 1);
    check("post_grant_hold", grant, g);
  endtask

  int p;
  int t_prev;

  initial begin
    // Reset values, with a pending request that must not be readied
    req0_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 2'b00);
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);

    // Round-robin: port 0 first, accepts FrameLen+1 apart
    req0_data  = 8'h11;
    req1_data  = 8'h22;
    req1_valid = 1'b1;
    reset      = 1'b0;
    #1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(p);
      check("rr_port", p, i % 2);
      if (i > 0) check("rr_gap", cyc - t_prev, FrameLen + 1);
      t_prev = cyc;
      check_frame(p == 1 ? 8'h22 : 8'h11, p == 1 ? 2'b10 : 2'b01, -1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Single byte 0xA5 from port 0
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    #1;
    check("single_ready", req0_ready, 1);
    wait_accept(p);
    check("single_port", p, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    check_frame(8'hA5, 2'b01, -1);

    // DFU strict priority
    dfu        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h11;
    req1_data  = 8'h22;
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_accept(p);
      check("dfu_port", p, 1);
      check("dfu_req0_ready", req0_ready, 0);
      check_frame(8'h22, 2'b10, -1);
    end

    // Flow control: CTS deasserted blocks, reassert accepts same cycle
    uart_cts   = 1'b1;
    req1_valid = 1'b0;
    dfu        = 1'b0;
    req0_data  = 8'h5A;
    #1;
    for (int i = 0; i < 100; i++) begin
      check("cts_block_ready", req0_ready, 0);
      check("cts_block_tx", uart_tx, 1);
      @(negedge clk);
      #1;
    end
    uart_cts = 1'b0;
    #1;
    check("cts_ready", req0_ready, 1);
    wait_accept(p);
    check("cts_port", p, 0);
    check_frame(8'h5A, 2'b01, 5);
    for (int i = 0; i < 20; i++) begin
      check("cts_next_blocked", req0_ready, 0);
      check("cts_next_idle", busy, 0);
      @(negedge clk);
      #1;
    end
    req0_valid = 1'b0;
    uart_cts   = 1'b0;
    @(negedge clk);

    // Reset mid-frame drops the frame and restores the round-robin pointer
    req0_valid = 1'b1;
    req0_data  = 8'hC3;
    #1;
    wait_accept(p);
    check("mid_port", p, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (16) @(negedge clk);
    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_tx", uart_tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
    reset = 1'b0;
    #1;
    wait_accept(p);
    check("post_rst_port", p, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_frame(8'hC3, 2'b01, -1);

`ifdef UART_TX_ARB_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0
    req0_valid = 1'b1;
    req0_data  = 8'h07;
    #1;
    wait_accept(p);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    check_frame(8'h07, 2'b01, -1);
    req0_valid = 1'b1;
    req0_data  = 8'h03;
    #1;
    wait_accept(p);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (37) @(negedge clk);
    check("parity_03", uart_tx, 0);
    repeat (8) @(negedge clk);
    check("parity_frame_end", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
